// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the single register-file write port between two
// writeback requesters, A (ALU result path) and B (load/memory return path).
//
// Ports:
//   CLK                 clock, all state updates on the rising edge
//   RESET               synchronous, active-low reset
//   STALL               blocks all acceptances this cycle
//   A_VALID/ADDR/DATA   requester A write request
//   A_READY             A accepted at this edge (combinational)
//   B_VALID/ADDR/DATA   requester B write request
//   B_READY             B accepted at this edge (combinational)
//   WRITE_ENABLE        registered write strobe to reg_file (never for reg 0)
//   WRITE_ADDRESS       registered write address to reg_file
//   WRITE_DATA          registered write data to reg_file
//   LAST_GRANT          0 = A won the last accepted request, 1 = B won
module reg_write_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic                  A_VALID,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DATA,
  output logic                  A_READY,
  input  logic                  B_VALID,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_DATA,
  output logic                  B_READY,
  output logic                  WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic                  LAST_GRANT
);

  logic                  write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  last_grant_q, last_grant_d;

  logic                  grant_a;
  logic                  grant_b;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Arbitration: on a conflict, round-robin favours whoever did not win last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (RESET && !STALL) begin
      if (A_VALID && B_VALID) begin
        if (FIXED_PRIORITY || last_grant_q) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = A_VALID;
        grant_b = B_VALID;
      end
    end
  end

  // Next-state for the registered write port and grant history.
  always_comb begin
    xfer            = grant_a | grant_b;
    sel_addr        = grant_a ? A_ADDR : B_ADDR;
    sel_data        = grant_a ? A_DATA : B_DATA;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    last_grant_d    = last_grant_q;
    if (xfer) begin
      // Register 0 is hard-wired: accept the request but suppress the strobe.
      write_enable_d  = (sel_addr != '0);
      write_address_d = sel_addr;
      write_data_d    = sel_data;
      last_grant_d    = grant_b;
    end
  end

  // State register; reset discards any write not yet presented.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      last_grant_q    <= 1'b1;
    end else begin
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      last_grant_q    <= last_grant_d;
    end
  end

  assign A_READY       = grant_a;
  assign B_READY       = grant_b;
  assign WRITE_ENABLE  = write_enable_q;
  assign WRITE_ADDRESS = write_address_q;
  assign WRITE_DATA    = write_data_q;
  assign LAST_GRANT    = last_grant_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: a round-robin instance (0) and a
// fixed-priority instance (1) driven by independent requesters, checked
// against a behavioural model with a per-instance expected-write queue.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic             CLK;
  logic             RESET;
  logic             STALL;
  logic [1:0]       av, bv;
  logic [1:0][4:0]  aa, ba;
  logic [1:0][31:0] ad, bd;
  logic [1:0]       a_rdy, b_rdy, we, lg;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;

  reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIORITY(1'b0)) u_rr (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .A_VALID(av[0]), .A_ADDR(aa[0]), .A_DATA(ad[0]), .A_READY(a_rdy[0]),
    .B_VALID(bv[0]), .B_ADDR(ba[0]), .B_DATA(bd[0]), .B_READY(b_rdy[0]),
    .WRITE_ENABLE(we[0]), .WRITE_ADDRESS(wa[0]), .WRITE_DATA(wd[0]),
    .LAST_GRANT(lg[0])
  );

  reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIORITY(1'b1)) u_fp (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .A_VALID(av[1]), .A_ADDR(aa[1]), .A_DATA(ad[1]), .A_READY(a_rdy[1]),
    .B_VALID(bv[1]), .B_ADDR(ba[1]), .B_DATA(bd[1]), .B_READY(b_rdy[1]),
    .WRITE_ENABLE(we[1]), .WRITE_ADDRESS(wa[1]), .WRITE_DATA(wd[1]),
    .LAST_GRANT(lg[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state (what the arbiter should hold after each edge)
  wr_t        q0[$];
  wr_t        q1[$];
  logic [1:0] m_last;
  logic [1:0][4:0]  m_addr;
  logic [1:0][31:0] m_data;
  logic [1:0] acc_a, acc_b;
  bit         started = 0;
  bit         gen_en  = 0;
  bit         refill  = 0;

  // Grant decision straight from the arbitration rules: bit0 = A, bit1 = B.
  function automatic logic [1:0] model_grant(input logic rst_n, input logic stall,
                                             input logic a_v, input logic b_v,
                                             input logic fixed, input logic last);
    if (!rst_n || stall) return 2'b00;
    if (a_v && b_v) return (fixed || last) ? 2'b01 : 2'b10;
    return {b_v, a_v};
  endfunction

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: advance at every rising edge and queue the write that should follow.
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] g;
      wr_t        w;
      g = model_grant(RESET, STALL, av[i], bv[i], (i == 1), m_last[i]);
      acc_a[i] = g[0];
      acc_b[i] = g[1];
      if (!RESET) begin
        if (i == 0) q0.delete(); else q1.delete();
        m_last[i] = 1'b1;
        m_addr[i] = '0;
        m_data[i] = '0;
      end else if (g != 2'b00) begin
        w.addr    = g[0] ? aa[i] : ba[i];
        w.data    = g[0] ? ad[i] : bd[i];
        m_last[i] = g[1];
        m_addr[i] = w.addr;
        m_data[i] = w.data;
        if (w.addr != 5'd0) begin
          if (i == 0) q0.push_back(w); else q1.push_back(w);
        end
      end
    end
    started = 1;
  end

  // Monitor: sample mid-cycle, pop expected writes when a strobe is due.
  always @(negedge CLK) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0] g;
        logic       has;
        wr_t        w;
        g   = model_grant(RESET, STALL, av[i], bv[i], (i == 1), m_last[i]);
        has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        w   = '0;
        if (has) w = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk("a_ready", i, 32'(a_rdy[i]), 32'(g[0]));
        chk("b_ready", i, 32'(b_rdy[i]), 32'(g[1]));
        chk("write_enable", i, 32'(we[i]), 32'(has));
        if (has && we[i]) begin
          chk("strobe_addr", i, 32'(wa[i]), 32'(w.addr));
          chk("strobe_data", i, wd[i], w.data);
        end
        chk("write_address", i, 32'(wa[i]), 32'(m_addr[i]));
        chk("write_data", i, wd[i], m_data[i]);
        chk("last_grant", i, 32'(lg[i]), 32'(m_last[i]));
      end
    end
  end

  task automatic set_a(input int i, input logic [4:0] a, input logic [31:0] d);
    av[i] = 1'b1; aa[i] = a; ad[i] = d;
  endtask

  task automatic set_b(input int i, input logic [4:0] a, input logic [31:0] d);
    bv[i] = 1'b1; ba[i] = a; bd[i] = d;
  endtask

  // Requesters: retire or refill accepted requests, optionally issue new ones.
  task automatic update_reqs();
    for (int i = 0; i < 2; i++) begin
      if (acc_a[i]) begin
        if (refill) set_a(i, 5'($urandom_range(1, 31)), $urandom);
        else av[i] = 1'b0;
      end
      if (acc_b[i]) begin
        if (refill) set_b(i, 5'($urandom_range(1, 31)), $urandom);
        else bv[i] = 1'b0;
      end
      if (gen_en && !av[i] && ($urandom % 2 == 0)) set_a(i, 5'($urandom % 32), $urandom);
      if (gen_en && !bv[i] && ($urandom % 2 == 0)) set_b(i, 5'($urandom % 32), $urandom);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    update_reqs();
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0;
    av = '0; bv = '0; aa = '0; ba = '0; ad = '0; bd = '0;
    acc_a = '0; acc_b = '0;
    repeat (2) step();
    RESET = 1'b1;

    // Single A write
    for (int i = 0; i < 2; i++) set_a(i, 5'd1, 32'd10);
    repeat (3) step();

    // Conflict straight out of reset
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_a(i, 5'd2, 32'h22);
      set_b(i, 5'd3, 32'h33);
    end
    repeat (4) step();

    // Sustained conflict with fresh data on every acceptance
    for (int i = 0; i < 2; i++) begin
      set_a(i, 5'd6, $urandom);
      set_b(i, 5'd7, $urandom);
    end
    refill = 1;
    repeat (6) step();
    refill = 0;
    repeat (4) step();

    // Write to register 0
    for (int i = 0; i < 2; i++) set_a(i, 5'd0, 32'd10);
    repeat (3) step();

    // Stall holds off B for three cycles
    for (int i = 0; i < 2; i++) set_b(i, 5'd5, 32'h55);
    STALL = 1'b1;
    repeat (3) step();
    STALL = 1'b0;
    repeat (3) step();

    // Reset right after an acceptance
    for (int i = 0; i < 2; i++) set_a(i, 5'd4, 32'h44);
    step();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    repeat (3) step();

    // Random traffic with stalls and occasional resets
    gen_en = 1;
    for (int c = 0; c < 800; c++) begin
      STALL = ($urandom % 5 == 0);
      RESET = !($urandom % 60 == 0);
      step();
    end

    // Drain
    gen_en = 0;
    STALL  = 1'b0;
    RESET  = 1'b1;
    repeat (10) step();
    @(negedge CLK);
    #1;
    chk("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
